// File: rtl/patt_gen_if.sv
// Control/serial-output bundle for patt_gen: the generator takes the slave side,
// the stimulus driver or link controller takes the master side.
interface patt_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic             pause;
  logic             abort;
  logic             err_inj;
  logic             data_out;
  logic             data_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_cnt, pause, abort, err_inj,
    input  data_out, data_valid, busy, done
  );

  modport slave (
    input  start, repeat_cnt, pause, abort, err_inj,
    output data_out, data_valid, busy, done
  );
endinterface

// File: rtl/patt_gen.sv
// Serial pattern generator: sends PATTERN MSB-first for a programmable number of
// repetitions with GAP idle cycles in between. Optional error inject: PATT_GEN_ERR_INJ_EN.
module patt_gen #(
  parameter int unsigned     WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = 6'b110101,
  parameter int unsigned     CNT_W   = 8,
  parameter int unsigned     GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  patt_gen_if.slave  bus
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] rep;
  logic [GW-1:0]    gcnt;
  logic             xfer;
  logic             inj;

  assign xfer = (state == S_SEND) && !bus.pause;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
      rep   <= '0;
      gcnt  <= '0;
    end else if (bus.abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rep   <= (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
            idx   <= IDX_TOP;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (idx != '0) begin
              idx <= idx - 1'b1;
            end else if (rep > CNT_W'(1)) begin
              rep <= rep - 1'b1;
              idx <= IDX_TOP;
              // With GAP=0 the next repetition starts on the very next edge.
              if (GAP > 0) begin
                state <= S_GAP;
                gcnt  <= GAP_LOAD;
              end
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_GAP: begin
          if (gcnt == '0) state <= S_SEND;
          else            gcnt  <= gcnt - 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PATT_GEN_ERR_INJ_EN
  logic flag;

  // Pending request survives pauses and gaps; it is consumed by the next transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  flag <= 1'b0;
    else if (state == S_IDLE)  flag <= 1'b0;
    else                       flag <= (flag && !xfer) || bus.err_inj;
  end

  assign inj = flag && (state == S_SEND);
`else
  logic unused_err_inj;
  assign unused_err_inj = bus.err_inj;
  assign inj = 1'b0;
`endif

  always_comb begin
    bus.data_out   = 1'b0;
    bus.data_valid = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      S_SEND: begin
        bus.data_valid = !bus.pause;
        bus.data_out   = PATTERN[idx] ^ inj;
        bus.busy       = 1'b1;
      end
      S_GAP:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_patt_gen.sv
// Directed bench for patt_gen with default parameters and a small looped-back detector model.
module tb_patt_gen;

  logic clk = 1'b0;
  logic rst;

  patt_gen_if #(.CNT_W(8)) bus();

  patt_gen #(
    .WIDTH   (6),
    .PATTERN (6'b110101),
    .CNT_W   (8),
    .GAP     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Detector model: shifts in each transferred bit, flags a full pattern the cycle after.
  logic [5:0] det_sh;
  logic       det_v;
  logic       det_match;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_sh <= '0;
      det_v  <= 1'b0;
    end else begin
      det_v <= bus.data_valid;
      if (bus.data_valid) det_sh <= {det_sh[4:0], bus.data_out};
    end
  end

  assign det_match = det_v && (det_sh == 6'b110101);

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] vlog, dlog, blog, donelog, mlog;

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.repeat_cnt = '0;
    bus.pause      = 1'b0;
    bus.abort      = 1'b0;
    bus.err_inj    = 1'b0;
  endtask

  // Called #1 after an edge in IDLE; edge k is the one that samples start.
  task automatic kick(input logic [7:0] r);
    bus.repeat_cnt = r;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
  endtask

  // Entry i of each log is the cycle after edge k+i.
  task automatic record(input int n, input logic [63:0] pm, input logic [63:0] sm,
                        input logic [63:0] am, input logic [63:0] em);
    vlog = '0; dlog = '0; blog = '0; donelog = '0; mlog = '0;
    for (int i = 0; i < n; i++) begin
      bus.pause   = pm[i];
      bus.start   = sm[i];
      bus.abort   = am[i];
      bus.err_inj = em[i];
      #1;
      vlog[i]    = bus.data_valid;
      dlog[i]    = bus.data_out;
      blog[i]    = bus.busy;
      donelog[i] = bus.done;
      mlog[i]    = det_match;
      @(posedge clk);
      #1;
    end
    bus.pause   = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.err_inj = 1'b0;
  endtask

  function automatic logic [31:0] bits_of(input int n);
    logic [31:0] b = '0;
    for (int i = 0; i < n; i++)
      if (vlog[i]) b = {b[30:0], dlog[i]};
    return b;
  endfunction

  function automatic int nbits_of(input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (vlog[i]) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.start      = 1'b1;
    bus.repeat_cnt = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.data_out !== 1'b0) $display("FAIL reset_data_out: got %b want 0", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", bus.data_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else pass_cnt++;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    record(4, '0, '0, '0, '0);
    total_cnt++;
    if (blog[3:0] !== 4'h0 || vlog[3:0] !== 4'h0)
      $display("FAIL reset_stays_idle: busy %b valid %b want 0000 0000", blog[3:0], vlog[3:0]);
    else pass_cnt++;
  endtask

  task automatic test_single();
    kick(8'd1);
    record(10, '0, '0, '0, '0);
    total_cnt++;
    if (vlog[9:0] !== 10'h03F) $display("FAIL single_valid: got %h want 03f", vlog[9:0]);
    else pass_cnt++;
    total_cnt++;
    if (bits_of(10) !== 32'b110101) $display("FAIL single_bits: got %b want 110101", bits_of(10));
    else pass_cnt++;
    total_cnt++;
    if (donelog[9:0] !== 10'h040) $display("FAIL single_done: got %h want 040", donelog[9:0]);
    else pass_cnt++;
    total_cnt++;
    if (mlog[9:0] !== 10'h040) $display("FAIL single_match: got %h want 040", mlog[9:0]);
    else pass_cnt++;
    total_cnt++;
    if (blog[9:0] !== 10'h03F) $display("FAIL single_busy: got %h want 03f", blog[9:0]);
    else pass_cnt++;
  endtask

  task automatic test_burst();
    kick(8'd3);
    record(26, '0, '0, '0, '0);
    total_cnt++;
    if (vlog[25:0] !== 26'h03F3F3F) $display("FAIL burst_valid: got %h want 03f3f3f", vlog[25:0]);
    else pass_cnt++;
    total_cnt++;
    if (nbits_of(26) != 18 || bits_of(26) !== {14'd0, {3{6'b110101}}})
      $display("FAIL burst_bits: got %0d bits %b want 18 bits 110101110101110101",
               nbits_of(26), bits_of(26));
    else pass_cnt++;
    total_cnt++;
    if (blog[25:0] !== 26'h03FFFFF) $display("FAIL burst_busy: got %h want 03fffff", blog[25:0]);
    else pass_cnt++;
    total_cnt++;
    if ((dlog[25:0] & 26'h000C0C0) !== 26'h0) $display("FAIL burst_gap_data: got %h want 0", dlog[25:0] & 26'h000C0C0);
    else pass_cnt++;
    total_cnt++;
    if (donelog[25:0] !== 26'h0400000) $display("FAIL burst_done: got %h want 0400000", donelog[25:0]);
    else pass_cnt++;
    total_cnt++;
    if (mlog[25:0] !== 26'h0404040) $display("FAIL burst_match: got %h want 0404040", mlog[25:0]);
    else pass_cnt++;

    kick(8'd0);
    record(10, '0, '0, '0, '0);
    total_cnt++;
    if (vlog[9:0] !== 10'h03F) $display("FAIL rep0_valid: got %h want 03f", vlog[9:0]);
    else pass_cnt++;
    total_cnt++;
    if (donelog[9:0] !== 10'h040) $display("FAIL rep0_done: got %h want 040", donelog[9:0]);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    kick(8'd1);
    record(12, 64'h1C, 64'h08, '0, '0);
    total_cnt++;
    if (vlog[11:0] !== 12'h1E3) $display("FAIL pause_valid: got %h want 1e3", vlog[11:0]);
    else pass_cnt++;
    total_cnt++;
    if ((dlog[11:0] & 12'h01C) !== 12'h0) $display("FAIL pause_hold_data: got %h want 000", dlog[11:0] & 12'h01C);
    else pass_cnt++;
    total_cnt++;
    if (bits_of(12) !== 32'b110101) $display("FAIL pause_bits: got %b want 110101", bits_of(12));
    else pass_cnt++;
    total_cnt++;
    if (donelog[11:0] !== 12'h200) $display("FAIL pause_done: got %h want 200", donelog[11:0]);
    else pass_cnt++;
    total_cnt++;
    if (blog[11:0] !== 12'h1FF) $display("FAIL pause_start_ignored: busy %h want 1ff", blog[11:0]);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    kick(8'd3);
    record(20, '0, '0, 64'h4000, '0);
    total_cnt++;
    if (vlog[19:0] !== 20'h03F3F) $display("FAIL abort_valid: got %h want 03f3f", vlog[19:0]);
    else pass_cnt++;
    total_cnt++;
    if (blog[19:0] !== 20'h07FFF) $display("FAIL abort_busy: got %h want 07fff", blog[19:0]);
    else pass_cnt++;
    total_cnt++;
    if (donelog[19:0] !== 20'h0) $display("FAIL abort_no_done: got %h want 00000", donelog[19:0]);
    else pass_cnt++;

    kick(8'd1);
    record(3, '0, '0, '0, '0);
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.data_out, bus.data_valid, bus.busy, bus.done} !== 4'b0000)
      $display("FAIL midreset_outputs: got %b want 0000",
               {bus.data_out, bus.data_valid, bus.busy, bus.done});
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    record(8, '0, '0, '0, '0);
    total_cnt++;
    if (blog[7:0] !== 8'h00 || donelog[7:0] !== 8'h00)
      $display("FAIL midreset_idle: busy %h done %h want 00 00", blog[7:0], donelog[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    kick(8'd1);
    record(16, '0, 64'hC0, '0, '0);
    total_cnt++;
    if (vlog[15:0] !== 16'h3F3F) $display("FAIL b2b_valid: got %h want 3f3f", vlog[15:0]);
    else pass_cnt++;
    total_cnt++;
    if (donelog[15:0] !== 16'h4040) $display("FAIL b2b_done: got %h want 4040", donelog[15:0]);
    else pass_cnt++;
    total_cnt++;
    if (bits_of(16) !== 32'b110101110101) $display("FAIL b2b_bits: got %b want 110101110101", bits_of(16));
    else pass_cnt++;
    record(3, '0, '0, '0, '0);
  endtask

  task automatic test_err_inj();
    logic [31:0] exp_bits;
    logic [15:0] exp_match;
`ifdef PATT_GEN_ERR_INJ_EN
    exp_bits  = 32'b111101110101;
    exp_match = 16'h4000;
`else
    exp_bits  = 32'b110101110101;
    exp_match = 16'h4040;
`endif
    kick(8'd2);
    record(18, '0, '0, '0, 64'h02);
    total_cnt++;
    if (bits_of(18) !== exp_bits) $display("FAIL errinj_bits: got %b want %b", bits_of(18), exp_bits);
    else pass_cnt++;
    total_cnt++;
    if (mlog[15:0] !== exp_match) $display("FAIL errinj_match: got %h want %h", mlog[15:0], exp_match);
    else pass_cnt++;
    total_cnt++;
    if (donelog[17:0] !== 18'h04000) $display("FAIL errinj_done: got %h want 04000", donelog[17:0]);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_burst();
    test_pause();
    test_abort();
    test_back_to_back();
    test_err_inj();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
